// File: rtl/pos_pkt_packer_pkg.sv
// MD_pkg: shared constants for the position packet packer.
//   POS_SLOT_WIDTH / POS_SLOTS_PER_BEAT / POS_BEAT_WIDTH : beat geometry
//   POS_FLAG_VALID        : flag word marking an occupied slot
//   STREAMING_TDEST_WIDTH : width of the AXI-Stream destination field
//   pos_state_t / ST_*    : packer FSM state encoding
package MD_pkg;
    localparam int unsigned POS_SLOT_WIDTH        = 128;
    localparam int unsigned POS_SLOTS_PER_BEAT    = 4;
    localparam int unsigned POS_BEAT_WIDTH        = POS_SLOT_WIDTH * POS_SLOTS_PER_BEAT;
    localparam logic [31:0] POS_FLAG_VALID        = 32'h1;
    localparam int unsigned STREAMING_TDEST_WIDTH = 8;

    typedef logic [2:0] pos_state_t;
    localparam pos_state_t ST_IDLE     = 3'd0;
    localparam pos_state_t ST_FILL     = 3'd1;
    localparam pos_state_t ST_WAIT_NET = 3'd2;
    localparam pos_state_t ST_HDR      = 3'd3;
    localparam pos_state_t ST_DATA     = 3'd4;
endpackage

// File: rtl/pos_pkt_packer_if.sv
// pos_pkt_packer_if: 512-bit AXI-Stream bundle carrying position packets.
//   tdata/tkeep/tvalid/tlast/tdest : source -> sink
//   tready                         : sink -> source
//   modport master : packet source, modport slave : packet sink
interface pos_pkt_packer_if;
    logic [MD_pkg::POS_BEAT_WIDTH-1:0]        tdata;
    logic [MD_pkg::POS_BEAT_WIDTH/8-1:0]      tkeep;
    logic                                     tvalid;
    logic                                     tlast;
    logic [MD_pkg::STREAMING_TDEST_WIDTH-1:0] tdest;
    logic                                     tready;

    modport master (output tdata, tkeep, tvalid, tlast, tdest, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/pos_pkt_beat_buf.sv
// pos_pkt_beat_buf: simple dual-port beat store, one write port and one
// registered read port (data appears the cycle after re_i).
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; rdata_o holds its value while re_i=0
module pos_pkt_beat_buf #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned WIDTH = 512,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/pos_pkt_packer.sv
// pos_pkt_packer: packs particle position records four per 512-bit beat,
// then sends a header beat (beat count) followed by the data beats.
//   ap_clk, ap_rst        : clock, synchronous active-high reset
//   pos_in_*              : record input with valid/ready handshake
//   dest_id               : destination, latched when the packet closes
//   network_pos_free      : network can take a new packet
//   M_AXIS_n2k_pos        : outgoing AXI-Stream (pos_pkt_packer_if.master)
//   busy                  : a packet is being filled or sent
// Optional macro POS_PKT_STATS_EN adds stat_pkt_cnt / stat_particle_cnt.
module pos_pkt_packer
    import MD_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 15
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             pos_in_valid,
    output logic                             pos_in_ready,
    input  logic [31:0]                      pos_in_x,
    input  logic [31:0]                      pos_in_y,
    input  logic [31:0]                      pos_in_z,
    input  logic                             pos_in_last,
    input  logic [STREAMING_TDEST_WIDTH-1:0] dest_id,
    input  logic                             network_pos_free,
    pos_pkt_packer_if.master                 M_AXIS_n2k_pos,
`ifdef POS_PKT_STATS_EN
    output logic [31:0]                      stat_pkt_cnt,
    output logic [31:0]                      stat_particle_cnt,
`endif
    output logic                             busy
);
    localparam int unsigned AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    pos_state_t                       state_q, state_d;
    logic [POS_BEAT_WIDTH-1:0]        acc_q, acc_d;
    logic [1:0]                       slot_q, slot_d;
    logic [AW-1:0]                    wbeat_q, wbeat_d;
    logic [CW-1:0]                    nbeats_q, nbeats_d;
    logic [AW-1:0]                    rd_idx_q, rd_idx_d;
    logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;

    logic                      accept, close, beat_we, rd_en, xfer, is_last;
    logic [AW-1:0]             rd_addr;
    logic [POS_SLOT_WIDTH-1:0] rec;
    logic [POS_BEAT_WIDTH-1:0] beat_wdata, rd_data;

    assign pos_in_ready = !ap_rst && (state_q == ST_IDLE || state_q == ST_FILL);
    assign accept       = pos_in_valid && pos_in_ready;
    assign rec          = {POS_FLAG_VALID, pos_in_x, pos_in_y, pos_in_z};
    assign close        = accept && (pos_in_last ||
                          (slot_q == 2'd3 && wbeat_q == AW'(MAX_BEATS - 1)));
    assign beat_we      = accept && (slot_q == 2'd3 || close);
    assign xfer         = M_AXIS_n2k_pos.tvalid && M_AXIS_n2k_pos.tready;
    assign is_last      = (CW'(rd_idx_q) == nbeats_q - CW'(1));

    // Unfilled slots above the current one stay zero because acc is cleared
    // after each beat write.
    always_comb begin
        beat_wdata = acc_q;
        for (int unsigned k = 0; k < POS_SLOTS_PER_BEAT; k++)
            if (slot_q == 2'(k)) beat_wdata[k*POS_SLOT_WIDTH +: POS_SLOT_WIDTH] = rec;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        slot_d   = slot_q;
        wbeat_d  = wbeat_q;
        nbeats_d = nbeats_q;
        dest_d   = dest_q;
        rd_idx_d = rd_idx_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        if (accept) begin
            if (beat_we) begin
                acc_d   = '0;
                slot_d  = '0;
                wbeat_d = close ? '0 : wbeat_q + AW'(1);
            end else begin
                acc_d  = beat_wdata;
                slot_d = slot_q + 2'd1;
            end
            if (close) begin
                nbeats_d = CW'(wbeat_q) + CW'(1);
                dest_d   = dest_id;
                state_d  = ST_WAIT_NET;
            end else begin
                state_d  = ST_FILL;
            end
        end
        case (state_q)
            ST_WAIT_NET: if (network_pos_free) state_d = ST_HDR;
            ST_HDR: begin
                // Prefetch beat 0 so it sits on the RAM output on DATA entry.
                rd_en    = 1'b1;
                rd_idx_d = '0;
                if (xfer) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = rd_idx_q + AW'(1);
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            slot_q   <= '0;
            wbeat_q  <= '0;
            nbeats_q <= '0;
            rd_idx_q <= '0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            slot_q   <= slot_d;
            wbeat_q  <= wbeat_d;
            nbeats_q <= nbeats_d;
            rd_idx_q <= rd_idx_d;
            dest_q   <= dest_d;
        end
    end

    pos_pkt_beat_buf #(.DEPTH(MAX_BEATS), .WIDTH(POS_BEAT_WIDTH), .AW(AW)) u_beat_buf (
        .clk_i   (ap_clk),
        .we_i    (beat_we),
        .waddr_i (wbeat_q),
        .wdata_i (beat_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // RAM output only advances on a transfer, so it doubles as the stalled beat.
    assign M_AXIS_n2k_pos.tvalid = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign M_AXIS_n2k_pos.tdata  = (state_q == ST_HDR) ? {16{32'(nbeats_q)}} : rd_data;
    assign M_AXIS_n2k_pos.tkeep  = '1;
    assign M_AXIS_n2k_pos.tlast  = (state_q == ST_DATA) && is_last;
    assign M_AXIS_n2k_pos.tdest  = dest_q;
    assign busy                  = (state_q != ST_IDLE);

`ifdef POS_PKT_STATS_EN
    logic [31:0] stat_pkt_cnt_q, stat_particle_cnt_q;
    logic [2:0]  beat_flags;

    always_comb begin
        beat_flags = '0;
        for (int unsigned k = 0; k < POS_SLOTS_PER_BEAT; k++)
            if (rd_data[k*POS_SLOT_WIDTH+96 +: 32] == POS_FLAG_VALID) beat_flags = beat_flags + 3'd1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stat_pkt_cnt_q      <= '0;
            stat_particle_cnt_q <= '0;
        end else if (state_q == ST_DATA && xfer) begin
            stat_particle_cnt_q <= stat_particle_cnt_q + 32'(beat_flags);
            if (is_last) stat_pkt_cnt_q <= stat_pkt_cnt_q + 32'd1;
        end
    end

    assign stat_pkt_cnt      = stat_pkt_cnt_q;
    assign stat_particle_cnt = stat_particle_cnt_q;
`endif
endmodule

// File: tb/tb_pos_pkt_packer.sv
// Self-checking bench for pos_pkt_packer: directed scenarios with random
// record data, expected beats built from the packing rules in a queue.
module tb_pos_pkt_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic         pos_in_valid, pos_in_last, network_pos_free, busy, pos_in_ready;
    logic [31:0]  pos_in_x, pos_in_y, pos_in_z;
    logic [7:0]   dest_id;
`ifdef POS_PKT_STATS_EN
    logic [31:0]  stat_pkt_cnt, stat_particle_cnt;
`endif

    pos_pkt_packer_if axis ();

    pos_pkt_packer #(.MAX_BEATS(15)) dut (
        .ap_clk           (clk),
        .ap_rst           (rst),
        .pos_in_valid     (pos_in_valid),
        .pos_in_ready     (pos_in_ready),
        .pos_in_x         (pos_in_x),
        .pos_in_y         (pos_in_y),
        .pos_in_z         (pos_in_z),
        .pos_in_last      (pos_in_last),
        .dest_id          (dest_id),
        .network_pos_free (network_pos_free),
        .M_AXIS_n2k_pos   (axis),
`ifdef POS_PKT_STATS_EN
        .stat_pkt_cnt      (stat_pkt_cnt),
        .stat_particle_cnt (stat_particle_cnt),
`endif
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [7:0]   dest;
        logic [63:0]  keep;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    checks = 0;
    int    errors = 0;
    int    tready_mode = 0;   // 0: always 1, 1: toggle, 2: held by main
    int    exp_pkts = 0;
    int    exp_parts = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // tready driver
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tready_mode == 0) axis.tready = 1'b1;
            else if (tready_mode == 1) axis.tready = ~axis.tready;
        end
    end

    // Monitor: capture transferred beats, check stalled beats hold still.
    logic         prev_stall = 1'b0;
    logic [511:0] prev_data;
    logic [7:0]   prev_dest;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", axis.tvalid, 1'b1);
                chk("stall_data", axis.tdata, prev_data);
                chk("stall_dest", axis.tdest, prev_dest);
            end
            if (axis.tvalid && axis.tready)
                got_q.push_back('{axis.tdata, axis.tlast, axis.tdest, axis.tkeep});
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_dest  = axis.tdest;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_rec(input logic [127:0] r, input logic last);
        int waited = 0;
        pos_in_valid = 1'b1;
        pos_in_x = r[95:64];
        pos_in_y = r[63:32];
        pos_in_z = r[31:0];
        pos_in_last = last;
        forever begin
            @(negedge clk);
            if (pos_in_ready) break;
            waited++;
            if (waited > 2000) begin
                checks++; errors++;
                $error("FAIL accept_timeout observed=%0d expected=<=2000", waited);
                break;
            end
        end
        @(posedge clk); #1;
        pos_in_valid = 1'b0;
        pos_in_last  = 1'b0;
    endtask

    // Builds n records, pushes the expected packet, then drives the records.
    task automatic send_pkt(input int n, input bit use_last, input bit ramp);
        logic [127:0] recs[$];
        logic [31:0]  x, y, z;
        logic [7:0]   d;
        beat_t        b;
        int           nb;
        nb = (n + 3) / 4;
        d  = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            if (ramp) begin
                x = 32'(i + 1) * 32'h00080000; y = x; z = x;
            end else begin
                x = $urandom; y = $urandom; z = $urandom;
            end
            recs.push_back({32'h1, x, y, z});
        end
        b.data = {16{32'(nb)}}; b.last = 1'b0; b.dest = d; b.keep = '1;
        exp_q.push_back(b);
        for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            for (int k = 0; k < 4; k++)
                if (4 * bi + k < n) b.data[128*k +: 128] = recs[4*bi+k];
            b.last = (bi == nb - 1);
            exp_q.push_back(b);
        end
        exp_pkts++;
        exp_parts += n;
        dest_id = d;
        for (int i = 0; i < n; i++) begin
            drive_rec(recs[i], use_last && (i == n - 1));
            if (i != n - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        int m;
        while (got_q.size() < exp_q.size() && w < 3000) begin
            @(negedge clk); #1; w++;
        end
        repeat (3) begin @(negedge clk); #1; end
        chk({tag, "_beats"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_b%0d_data", tag, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s_b%0d_last", tag, i), got_q[i].last, exp_q[i].last);
            chk($sformatf("%s_b%0d_dest", tag, i), got_q[i].dest, exp_q[i].dest);
            chk($sformatf("%s_b%0d_keep", tag, i), got_q[i].keep, exp_q[i].keep);
        end
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pos_in_valid = 1'b0; pos_in_last = 1'b0;
        pos_in_x = '0; pos_in_y = '0; pos_in_z = '0;
        dest_id = '0; network_pos_free = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", pos_in_ready, 1'b0);
        chk("rst_tvalid", axis.tvalid, 1'b0);
        chk("rst_tlast", axis.tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", pos_in_ready, 1'b1);
        chk("busy_after_rst", busy, 1'b0);
        @(posedge clk); #1;

        // 60 ramp records, no last: close on capacity, check 2-cycle latency
        send_pkt(60, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_c1_tvalid", axis.tvalid, 1'b0);
        @(negedge clk);
        chk("lat_c2_tvalid", axis.tvalid, 1'b1);
        chk("lat_c2_hdr", axis.tdata, {16{32'h0000000F}});
        #1;
        drain("full60");

        // 5 records with last: partial final beat
        send_pkt(5, 1'b1, 1'b0);
        drain("pkt5");
`ifdef POS_PKT_STATS_EN
        chk("stat_pkt_cnt", stat_pkt_cnt, 32'(exp_pkts));
        chk("stat_particle_cnt", stat_particle_cnt, 32'(exp_parts));
`endif

        // Network busy for 10 cycles after close
        network_pos_free = 1'b0;
        send_pkt(7, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("netwait_tvalid", axis.tvalid, 1'b0);
            chk("netwait_ready", pos_in_ready, 1'b0);
        end
        @(posedge clk); #1; network_pos_free = 1'b1;
        @(negedge clk);
        chk("free_c0_tvalid", axis.tvalid, 1'b0);
        @(negedge clk);
        chk("free_c1_tvalid", axis.tvalid, 1'b1);
        #1;
        @(posedge clk); #1; network_pos_free = 1'b0;   // drop after HDR: packet continues
        drain("netwait");
        network_pos_free = 1'b1;

        // tready toggling, random size packets back to back (backpressure)
        tready_mode = 1;
        send_pkt(int'($urandom_range(9, 60)), 1'b1, 1'b0);
        drain("toggle");
        send_pkt(int'($urandom_range(1, 60)), 1'b1, 1'b0);
        send_pkt(int'($urandom_range(1, 60)), 1'b1, 1'b0);
        drain("b2b");
        tready_mode = 0;

        // Reset while beat 3 is pending
        tready_mode = 2;
        axis.tready = 1'b1;
        send_pkt(20, 1'b1, 1'b0);
        for (int w = 0; w < 500 && got_q.size() < 3; w++) begin @(negedge clk); #1; end
        @(posedge clk); #1; axis.tready = 1'b0;
        @(negedge clk);
        chk("mid_beat3_valid", axis.tvalid, 1'b1);
        chk("mid_beat3_data", axis.tdata, exp_q[3].data);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", axis.tvalid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", pos_in_ready, 1'b1);
        axis.tready = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_more_beats", got_q.size(), 3);
        got_q.delete();
        exp_q.delete();
        tready_mode = 0;
        @(posedge clk); #1;
        send_pkt(9, 1'b1, 1'b0);
        drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
